shru_dcache_arbiter: RTL and testbench
======================================

SHRU_DCACHE_ARBITER -- requirements
Module: shru_dcache_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of the write and read data paths.
REQ-002 Parameter ADDR_WIDTH, default 12: request page-offset width.
REQ-003 Parameter MAX_OUTSTANDING, default 2: maximum accepted requests without a response (power of 2, ≥1).
REQ-004 Port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 Ports lsu_req_i / shru_req_i, input, 1 each: request valid, LSU (port 0) / shadow-register unit (port 1).
REQ-007 Ports lsu_addr_i / shru_addr_i, input, ADDR_WIDTH each; lsu_we_i / shru_we_i, input, 1; lsu_wdata_i / shru_wdata_i, input, DATA_WIDTH; lsu_be_i / shru_be_i, input, DATA_WIDTH/8.
REQ-008 Ports lsu_gnt_o / shru_gnt_o, output, 1: request accepted this cycle.
REQ-009 Ports lsu_rvalid_o / shru_rvalid_o, output, 1; rdata_o, output, DATA_WIDTH: routed response.
REQ-010 Port shru_urgent_i, input, 1: a pending mret restore needs the shadow-register unit served ahead of round-robin.
REQ-011 Ports req_o, output, 1; addr_o, output, ADDR_WIDTH; we_o, output, 1; wdata_o, output, DATA_WIDTH; be_o, output, DATA_WIDTH/8: downstream cache request.
REQ-012 Ports gnt_i, input, 1; rvalid_i, input, 1; rdata_i, input, DATA_WIDTH: downstream cache handshake; responses return in request order.
REQ-013 Port busy_o, output, 1: a request is held or a response is outstanding.
REQ-014 Port err_o, output, 1: sticky protocol error flag.

Function
REQ-015 The downstream handshake completes on req_o && gnt_i; the winning upstream gnt_o equals that term combinationally, and the other gnt_o is 0.
REQ-016 The FSM has states IDLE and HOLD; in IDLE the winner is chosen each cycle from the requests present.
REQ-017 Arbitration in IDLE: if shru_urgent_i && shru_req_i, SHRU wins; else if exactly one request is present, that requester wins; else the round-robin pointer wins.
REQ-018 The round-robin pointer toggles to the other requester only on a completed handshake by the current favourite.
REQ-019 IDLE with req_o=1 and gnt_i=0 transitions to HOLD with the winner latched; HOLD drives only the latched owner's address, we, wdata and be, ignoring shru_urgent_i, until gnt_i, then returns to IDLE.
REQ-020 In HOLD, if the latched owner drops its request (protocol violation), set err_o, deassert req_o and return to IDLE.
REQ-021 An owner FIFO of MAX_OUTSTANDING entries pushes the winner ID on each handshake and pops on rvalid_i.
REQ-022 rvalid_i is routed to the rvalid_o of the FIFO head; rdata_o = rdata_i combinationally.
REQ-023 When the FIFO is full, req_o=0 and both gnt_o are 0; a push and a pop in the same cycle leave the count unchanged.
REQ-024 Because req_o is 0 when the FIFO is full, no push can coincide with a full FIFO.
REQ-025 rvalid_i with an empty FIFO sets err_o; both rvalid_o stay 0 and the count stays 0 (no underflow wrap).
REQ-026 busy_o = (state==HOLD) || (count != 0).
REQ-027 Handshake latency is zero: a request is granted in the same cycle as gnt_i when it wins.

Reset
REQ-028 When rst_i is asserted: state=IDLE, FIFO empty, round-robin favours LSU, err_o=0, and all outputs are 0, including while rst_i stays high.
REQ-029 Reset mid-transaction discards held requests and outstanding IDs; a rvalid_i arriving after reset sets err_o.

Verification
REQ-030 Both requesting, gnt_i=1 for 2 cycles, responses returned -> LSU granted first, then SHRU; rvalid routed LSU then SHRU.
REQ-031 Both requesting with shru_urgent_i=1 -> SHRU granted first; pointer unchanged (still LSU).
REQ-032 LSU requests with gnt_i=0 for 3 cycles while SHRU asserts urgent -> state HOLD; addr_o stays LSU's; LSU granted on the 4th cycle.
REQ-033 Two handshakes with no rvalid -> req_o=0 and the third request waits; one rvalid_i lets it through the following cycle.
REQ-034 rvalid_i=1 with count 0 -> err_o=1 and stays high until rst_i.
REQ-035 rst_i pulse with one outstanding -> busy_o=0 immediately; all outputs 0 while rst_i=1.

Source files
------------

// File: rtl/shru_dcache_arbiter.sv
// Two-port arbiter sharing one data-cache port between the LSU and the shadow-register unit.
// Round-robin with an urgent override, a HOLD state for stalled grants, and an owner FIFO for in-order responses.
module shru_dcache_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    lsu_req_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  input  logic                    shru_req_i,
  input  logic [ADDR_WIDTH-1:0]   shru_addr_i,
  input  logic                    shru_we_i,
  input  logic [DATA_WIDTH-1:0]   shru_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] shru_be_i,
  output logic                    shru_gnt_o,
  output logic                    shru_rvalid_o,
  input  logic                    shru_urgent_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    req_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    we_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic                    gnt_i,
  input  logic                    rvalid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  output logic                    busy_o,
  output logic                    err_o
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_q, rr_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               fifo_q [MAX_OUTSTANDING];

  logic winner, win_req, full, empty, req_int, hs, pop, head;

  // Winner: latched owner in HOLD, otherwise urgent SHRU, sole requester, then round-robin favourite.
  always_comb begin
    winner = rr_q;
    if (state_q == HOLD)                 winner = owner_q;
    else if (shru_urgent_i && shru_req_i) winner = 1'b1;
    else if (lsu_req_i ^ shru_req_i)     winner = shru_req_i;
  end

  assign win_req = winner ? shru_req_i : lsu_req_i;
  assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (count_q == '0);
  assign req_int = !rst_i && win_req && !full;
  assign hs      = req_int && gnt_i;
  assign pop     = rvalid_i && !empty;
  assign head    = fifo_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    err_d    = err_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      IDLE: if (req_int && !gnt_i) begin
        state_d = HOLD;
        owner_d = winner;
      end
      HOLD: if (!win_req) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (hs) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (hs && (winner == rr_q)) rr_d = ~rr_q;
    if (rvalid_i && empty) err_d = 1'b1;
    if (hs) wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (hs && !pop)      count_d = count_q + 1'b1;
    else if (!hs && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      err_q    <= err_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Owner IDs are payload; only the pointers and count need a reset.
  always_ff @(posedge clk_i) begin
    if (hs) fifo_q[wr_ptr_q] <= winner;
  end

  assign req_o         = req_int;
  assign lsu_gnt_o     = hs && !winner;
  assign shru_gnt_o    = hs && winner;
  assign lsu_rvalid_o  = !rst_i && pop && !head;
  assign shru_rvalid_o = !rst_i && pop && head;
  assign rdata_o       = rst_i ? '0 : rdata_i;
  assign addr_o        = rst_i ? '0 : (winner ? shru_addr_i : lsu_addr_i);
  assign we_o          = !rst_i && (winner ? shru_we_i : lsu_we_i);
  assign wdata_o       = rst_i ? '0 : (winner ? shru_wdata_i : lsu_wdata_i);
  assign be_o          = rst_i ? '0 : (winner ? shru_be_i : lsu_be_i);
  assign busy_o        = !rst_i && ((state_q == HOLD) || !empty);
  assign err_o         = err_q;
endmodule

// File: tb/tb_shru_dcache_arbiter.sv
// Testbench for shru_dcache_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_shru_dcache_arbiter;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int MAXO = 2;

  logic clk_i = 0, rst_i = 1;
  logic lsu_req_i = 0, shru_req_i = 0, shru_urgent_i = 0, gnt_i = 0, rvalid_i = 0;
  logic lsu_we_i = 0, shru_we_i = 0;
  logic [AW-1:0] lsu_addr_i = 0, shru_addr_i = 0, addr_o;
  logic [DW-1:0] lsu_wdata_i = 0, shru_wdata_i = 0, rdata_i = 0, rdata_o, wdata_o;
  logic [DW/8-1:0] lsu_be_i = 0, shru_be_i = 0, be_o;
  logic lsu_gnt_o, shru_gnt_o, lsu_rvalid_o, shru_rvalid_o, req_o, we_o, busy_o, err_o;

  int tests = 0, failed = 0;

  shru_dcache_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_be_i(lsu_be_i), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
    .shru_req_i(shru_req_i), .shru_addr_i(shru_addr_i), .shru_we_i(shru_we_i),
    .shru_wdata_i(shru_wdata_i), .shru_be_i(shru_be_i), .shru_gnt_o(shru_gnt_o), .shru_rvalid_o(shru_rvalid_o),
    .shru_urgent_i(shru_urgent_i), .rdata_o(rdata_o),
    .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: who is being held, who is favoured, and the in-order queue of owners awaiting data.
  bit m_hold, m_owner, m_fav, m_err;
  int m_q[$];

  function automatic void predict(output int win, output bit wreq, output bit ereq);
    if (m_hold) win = m_owner;
    else if (shru_urgent_i && shru_req_i) win = 1;
    else if (lsu_req_i && !shru_req_i) win = 0;
    else if (shru_req_i && !lsu_req_i) win = 1;
    else win = m_fav;
    wreq = (win == 1) ? shru_req_i : lsu_req_i;
    ereq = !rst_i && wreq && (m_q.size() < MAXO);
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    int win; bit wreq, ereq;
    if (rst_i) begin
      m_hold = 0; m_owner = 0; m_fav = 0; m_err = 0; m_q.delete();
    end else begin
      predict(win, wreq, ereq);
      if (rvalid_i) begin
        if (m_q.size() == 0) m_err = 1;
        else void'(m_q.pop_front());
      end
      if (ereq && gnt_i) begin
        m_q.push_back(win);
        if (win == int'(m_fav)) m_fav = !m_fav;
        m_hold = 0;
      end else if (m_hold && !wreq) begin
        m_err = 1; m_hold = 0;
      end else if (!m_hold && ereq) begin
        m_hold = 1; m_owner = win[0];
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic idle_inputs();
    lsu_req_i = 0; shru_req_i = 0; shru_urgent_i = 0; gnt_i = 0; rvalid_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; idle_inputs();
    tick(); tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    lsu_req_i = 1; shru_req_i = 1; gnt_i = 1; rvalid_i = 1; rdata_i = 64'hDEAD_BEEF_0123_4567;
    lsu_addr_i = 12'h5A5; lsu_we_i = 1; lsu_be_i = 8'hFF; lsu_wdata_i = 64'h1;
    tick(); tick();
    tests++; if ({req_o, lsu_gnt_o, shru_gnt_o, lsu_rvalid_o, shru_rvalid_o, busy_o, err_o, we_o} !== 8'h0) begin
      failed++; $display("FAIL reset_ctrl got %b want 00000000", {req_o, lsu_gnt_o, shru_gnt_o, lsu_rvalid_o, shru_rvalid_o, busy_o, err_o, we_o}); end
    tests++; if (rdata_o !== '0 || addr_o !== '0 || wdata_o !== '0 || be_o !== '0) begin
      failed++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%h want 0", rdata_o, addr_o, wdata_o, be_o); end
    do_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    lsu_addr_i = 12'h111; shru_addr_i = 12'h222;
    lsu_req_i = 1; shru_req_i = 1; gnt_i = 1; #3;
    tests++; if ({lsu_gnt_o, shru_gnt_o} !== 2'b10 || addr_o !== 12'h111) begin
      failed++; $display("FAIL rr_first gnt=%b addr=%h want 10 111", {lsu_gnt_o, shru_gnt_o}, addr_o); end
    tick();
    tests++; if ({lsu_gnt_o, shru_gnt_o} !== 2'b01 || addr_o !== 12'h222) begin
      failed++; $display("FAIL rr_second gnt=%b addr=%h want 01 222", {lsu_gnt_o, shru_gnt_o}, addr_o); end
    tick();
    idle_inputs(); rvalid_i = 1; rdata_i = 64'hAAAA; #3;
    tests++; if ({lsu_rvalid_o, shru_rvalid_o} !== 2'b10 || rdata_o !== 64'hAAAA) begin
      failed++; $display("FAIL rr_rvalid_lsu rv=%b rdata=%h want 10 aaaa", {lsu_rvalid_o, shru_rvalid_o}, rdata_o); end
    tick(); rdata_i = 64'hBBBB; #3;
    tests++; if ({lsu_rvalid_o, shru_rvalid_o} !== 2'b01 || rdata_o !== 64'hBBBB) begin
      failed++; $display("FAIL rr_rvalid_shru rv=%b rdata=%h want 01 bbbb", {lsu_rvalid_o, shru_rvalid_o}, rdata_o); end
    tick(); rvalid_i = 0; #3;
    tests++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      failed++; $display("FAIL rr_drained busy=%b err=%b want 0 0", busy_o, err_o); end
  endtask

  task automatic test_urgent();
    do_reset();
    lsu_req_i = 1; shru_req_i = 1; shru_urgent_i = 1; gnt_i = 1; #3;
    tests++; if ({lsu_gnt_o, shru_gnt_o} !== 2'b01) begin
      failed++; $display("FAIL urgent_first gnt=%b want 01", {lsu_gnt_o, shru_gnt_o}); end
    tick(); shru_urgent_i = 0; #3;
    tests++; if ({lsu_gnt_o, shru_gnt_o} !== 2'b10) begin
      failed++; $display("FAIL urgent_ptr_kept gnt=%b want 10", {lsu_gnt_o, shru_gnt_o}); end
    tick(); idle_inputs(); rvalid_i = 1; tick(); tick(); rvalid_i = 0;
  endtask

  task automatic test_hold();
    do_reset();
    lsu_addr_i = 12'h3C3; shru_addr_i = 12'h4D4;
    lsu_req_i = 1; gnt_i = 0; #3;
    tests++; if (req_o !== 1'b1 || addr_o !== 12'h3C3 || lsu_gnt_o !== 1'b0) begin
      failed++; $display("FAIL hold_enter req=%b addr=%h gnt=%b want 1 3c3 0", req_o, addr_o, lsu_gnt_o); end
    tick(); shru_req_i = 1; shru_urgent_i = 1;
    for (int i = 0; i < 2; i++) begin
      #3;
      tests++; if (busy_o !== 1'b1 || addr_o !== 12'h3C3 || {lsu_gnt_o, shru_gnt_o} !== 2'b00) begin
        failed++; $display("FAIL hold_stay%0d busy=%b addr=%h gnt=%b want 1 3c3 00", i, busy_o, addr_o, {lsu_gnt_o, shru_gnt_o}); end
      tick();
    end
    gnt_i = 1; #3;
    tests++; if ({lsu_gnt_o, shru_gnt_o} !== 2'b10 || addr_o !== 12'h3C3) begin
      failed++; $display("FAIL hold_grant gnt=%b addr=%h want 10 3c3", {lsu_gnt_o, shru_gnt_o}, addr_o); end
    tick(); #3;
    tests++; if ({lsu_gnt_o, shru_gnt_o} !== 2'b01 || addr_o !== 12'h4D4) begin
      failed++; $display("FAIL hold_then_urgent gnt=%b addr=%h want 01 4d4", {lsu_gnt_o, shru_gnt_o}, addr_o); end
    tick(); idle_inputs(); rvalid_i = 1; tick(); tick(); rvalid_i = 0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    lsu_req_i = 1; gnt_i = 1;
    tick(); tick(); #3;
    tests++; if (req_o !== 1'b0 || lsu_gnt_o !== 1'b0 || busy_o !== 1'b1) begin
      failed++; $display("FAIL full_block req=%b gnt=%b busy=%b want 0 0 1", req_o, lsu_gnt_o, busy_o); end
    tick(); rvalid_i = 1; #3;
    tests++; if (req_o !== 1'b0 || lsu_rvalid_o !== 1'b1) begin
      failed++; $display("FAIL full_pop req=%b rvalid=%b want 0 1", req_o, lsu_rvalid_o); end
    tick(); #3;
    tests++; if (lsu_gnt_o !== 1'b1 || lsu_rvalid_o !== 1'b1) begin
      failed++; $display("FAIL push_pop gnt=%b rvalid=%b want 1 1", lsu_gnt_o, lsu_rvalid_o); end
    tick(); rvalid_i = 0; #3;
    tests++; if (lsu_gnt_o !== 1'b1) begin
      failed++; $display("FAIL count_kept gnt=%b want 1", lsu_gnt_o); end
    tick(); #3;
    tests++; if (req_o !== 1'b0) begin
      failed++; $display("FAIL full_again req=%b want 0", req_o); end
    idle_inputs(); rvalid_i = 1; tick(); tick(); rvalid_i = 0;
  endtask

  task automatic test_errors();
    do_reset();
    rvalid_i = 1; #3;
    tests++; if ({lsu_rvalid_o, shru_rvalid_o} !== 2'b00) begin
      failed++; $display("FAIL underflow_rvalid rv=%b want 00", {lsu_rvalid_o, shru_rvalid_o}); end
    tick(); rvalid_i = 0; tick(); tick(); #3;
    tests++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      failed++; $display("FAIL underflow_err err=%b busy=%b want 1 0", err_o, busy_o); end
    do_reset();
    lsu_req_i = 1; gnt_i = 0; tick();
    lsu_req_i = 0; shru_req_i = 0; #3;
    tests++; if (req_o !== 1'b0 || err_o !== 1'b0) begin
      failed++; $display("FAIL drop_req req=%b err=%b want 0 0", req_o, err_o); end
    tick(); #3;
    tests++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      failed++; $display("FAIL drop_err err=%b busy=%b want 1 0", err_o, busy_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lsu_req_i = 1; gnt_i = 1; tick(); gnt_i = 0; #2;
    tests++; if (busy_o !== 1'b1) begin
      failed++; $display("FAIL mid_busy busy=%b want 1", busy_o); end
    rst_i = 1; #1;
    tests++; if ({busy_o, req_o, lsu_gnt_o, err_o} !== 4'b0000) begin
      failed++; $display("FAIL mid_reset busy/req/gnt/err=%b want 0000", {busy_o, req_o, lsu_gnt_o, err_o}); end
    tick(); rst_i = 0; idle_inputs(); rvalid_i = 1; #3;
    tests++; if ({lsu_rvalid_o, shru_rvalid_o} !== 2'b00) begin
      failed++; $display("FAIL post_reset_rvalid rv=%b want 00", {lsu_rvalid_o, shru_rvalid_o}); end
    tick(); rvalid_i = 0; #3;
    tests++; if (err_o !== 1'b1) begin
      failed++; $display("FAIL post_reset_err err=%b want 1", err_o); end
  endtask

  task automatic test_random();
    int win; bit wreq, ereq;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      lsu_req_i = ($urandom_range(0, 3) != 0);
      shru_req_i = ($urandom_range(0, 2) != 0);
      if (m_hold && $urandom_range(0, 9) != 0) begin
        if (m_owner) shru_req_i = 1; else lsu_req_i = 1;
      end
      shru_urgent_i = ($urandom_range(0, 3) == 0);
      gnt_i = $urandom_range(0, 1);
      rvalid_i = (m_q.size() != 0 || $urandom_range(0, 30) == 0) && ($urandom_range(0, 2) == 0);
      lsu_addr_i = AW'($urandom); shru_addr_i = AW'($urandom);
      lsu_we_i = $urandom_range(0, 1); shru_we_i = $urandom_range(0, 1);
      lsu_wdata_i = {$urandom, $urandom}; shru_wdata_i = {$urandom, $urandom};
      lsu_be_i = 8'($urandom); shru_be_i = 8'($urandom);
      rdata_i = {$urandom, $urandom};
      #3;
      predict(win, wreq, ereq);
      tests++; if (req_o !== ereq || lsu_gnt_o !== (ereq && gnt_i && win == 0) || shru_gnt_o !== (ereq && gnt_i && win == 1)) begin
        failed++; $display("FAIL rand_req c=%0d req/gl/gs=%b%b%b want %b%b%b", c, req_o, lsu_gnt_o, shru_gnt_o,
                           ereq, ereq && gnt_i && win == 0, ereq && gnt_i && win == 1); end
      tests++; if (lsu_rvalid_o !== (rvalid_i && m_q.size() != 0 && m_q[0] == 0) ||
                   shru_rvalid_o !== (rvalid_i && m_q.size() != 0 && m_q[0] == 1) || rdata_o !== rdata_i) begin
        failed++; $display("FAIL rand_rvalid c=%0d rv=%b%b qsize=%0d", c, lsu_rvalid_o, shru_rvalid_o, m_q.size()); end
      tests++; if (addr_o !== (win == 1 ? shru_addr_i : lsu_addr_i) || wdata_o !== (win == 1 ? shru_wdata_i : lsu_wdata_i) ||
                   we_o !== (win == 1 ? shru_we_i : lsu_we_i) || be_o !== (win == 1 ? shru_be_i : lsu_be_i)) begin
        failed++; $display("FAIL rand_mux c=%0d addr=%h winner=%0d", c, addr_o, win); end
      tests++; if (busy_o !== (m_hold || m_q.size() != 0) || err_o !== m_err) begin
        failed++; $display("FAIL rand_status c=%0d busy=%b err=%b want %b %b", c, busy_o, err_o, m_hold || m_q.size() != 0, m_err); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_urgent();
    test_hold();
    test_fifo_full();
    test_errors();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
